// File: rtl/microseq_ctrl.sv
// Control sequencer for the 10-bit single-bus datapath: FETCH, then 1-3 execute steps.
// Optional retired-instruction counter output RETIRED enabled by defining INSTR_CNT_EN.
module microseq_ctrl #(
  parameter int unsigned DW  = 10,
  parameter int unsigned AW  = 2,
  parameter int unsigned FNW = 4
) (
  input  logic           CLKb,
  input  logic           RSTb,
  input  logic           STEP,
  input  logic [DW-1:0]  INSTR,
  output logic           IRin,
  output logic           Ext,
  output logic [AW-1:0]  WRA,
  output logic           ENW,
  output logic [AW-1:0]  RDA,
  output logic           ENR,
  output logic           Ain,
  output logic           Gin,
  output logic           Gout,
  output logic [FNW-1:0] ALUFN,
  output logic           DONE,
  output logic           HALTED,
  output logic [2:0]     TSTEP
`ifdef INSTR_CNT_EN
  ,
  output logic [7:0]     RETIRED
`endif
);

  localparam logic [FNW-1:0] OP_LD   = FNW'(0);
  localparam logic [FNW-1:0] OP_MV   = FNW'(1);
  localparam logic [FNW-1:0] OP_HALT = FNW'(2);
  localparam logic [FNW-1:0] OP_NOP  = FNW'(3);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EX1   = 3'd1,
    S_EX2   = 3'd2,
    S_EX3   = 3'd3,
    S_HALT  = 3'd7
  } state_t;

  state_t state, state_n;

  logic [FNW-1:0] op;
  logic [AW-1:0]  rx;
  logic [AW-1:0]  ry;
  logic           act;
  logic           unused_instr;

  assign op           = INSTR[DW-1 -: FNW];
  assign rx           = INSTR[DW-FNW-1 -: AW];
  assign ry           = INSTR[DW-FNW-AW-1 -: AW];
  assign unused_instr = ^INSTR[DW-FNW-2*AW-1:0];
  // Strobes are suppressed while stalled and while reset is asserted.
  assign act          = STEP && RSTb;

  always_ff @(posedge CLKb or negedge RSTb) begin
    if (!RSTb) state <= S_FETCH;
    else       state <= state_n;
  end

  // Next-state and strobe decode from state register and live INSTR.
  always_comb begin
    state_n = state;
    IRin    = 1'b0;
    Ext     = 1'b0;
    WRA     = '0;
    ENW     = 1'b0;
    RDA     = '0;
    ENR     = 1'b0;
    Ain     = 1'b0;
    Gin     = 1'b0;
    Gout    = 1'b0;
    ALUFN   = '0;
    DONE    = 1'b0;
    HALTED  = (state == S_HALT);
    TSTEP   = 3'(state);
    if (act) begin
      case (state)
        S_FETCH: begin
          Ext     = 1'b1;
          IRin    = 1'b1;
          state_n = S_EX1;
        end
        S_EX1: begin
          if (op == OP_LD) begin
            Ext     = 1'b1;
            ENW     = 1'b1;
            WRA     = rx;
            DONE    = 1'b1;
            state_n = S_FETCH;
          end else if (op == OP_MV) begin
            ENR     = 1'b1;
            RDA     = ry;
            ENW     = 1'b1;
            WRA     = rx;
            DONE    = 1'b1;
            state_n = S_FETCH;
          end else if (op == OP_HALT) begin
            state_n = S_HALT;
          end else if (op == OP_NOP) begin
            DONE    = 1'b1;
            state_n = S_FETCH;
          end else begin
            ENR     = 1'b1;
            RDA     = rx;
            Ain     = 1'b1;
            state_n = S_EX2;
          end
        end
        S_EX2: begin
          ENR     = 1'b1;
          RDA     = ry;
          Gin     = 1'b1;
          ALUFN   = op;
          state_n = S_EX3;
        end
        S_EX3: begin
          Gout    = 1'b1;
          ENW     = 1'b1;
          WRA     = rx;
          ALUFN   = op;
          DONE    = 1'b1;
          state_n = S_FETCH;
        end
        S_HALT:  state_n = S_HALT;
        default: state_n = S_FETCH;
      endcase
    end
  end

`ifdef INSTR_CNT_EN
  // DONE is already qualified by STEP, so it marks a retiring edge.
  always_ff @(posedge CLKb or negedge RSTb) begin
    if (!RSTb)     RETIRED <= 8'd0;
    else if (DONE) RETIRED <= RETIRED + 8'd1;
  end
`endif

endmodule

// File: doc/microseq_ctrl.md
Name: microseq_ctrl

Overview:
- FSM-based control sequencer for the 10-bit single-bus datapath: instruction register, 4-entry register file, two-stage ALU (A/G registers) and external-input tri-state buffer.
- Fetches an instruction from the external bus, then steps through 1-3 execute cycles, driving the enables, register addresses and ALU function code.
- Drives at most one bus source per cycle and exposes its step, done and halt status to the output/display logic.

Parameters:
DW, 10, data/instruction width
AW, 2, register address width (2**AW registers)
FNW, 4, ALU function / opcode width

Ports:
CLKb  input  1  clock; all state changes on the rising edge
RSTb  input  1  asynchronous active-low reset
STEP  input  1  advance enable; FSM moves only when 1 (tie to 1 for free-running)
INSTR  input  DW  current instruction register contents
IRin  output  1  instruction register load enable
Ext  output  1  external-input tri-state buffer drives BUS
WRA  output  AW  register file write address
ENW  output  1  register file write enable
RDA  output  AW  register file read port 0 address
ENR  output  1  register file read port 0 drives BUS
Ain  output  1  ALU A register load
Gin  output  1  ALU G register load
Gout  output  1  ALU G drives BUS
ALUFN  output  FNW  ALU function select
DONE  output  1  final execute cycle of the instruction
HALTED  output  1  FSM is in HALT
TSTEP  output  3  state code: FETCH=0, EX1=1, EX2=2, EX3=3, HALT=7

Behaviour:
- Instruction fields: OP=INSTR[9:6], RX=INSTR[5:4], RY=INSTR[3:2]; INSTR[1:0] ignored.
- Opcodes:
  - 0000 LD: RX <- external bus.
  - 0001 MV: RX <- RY.
  - 0010 HALT.
  - 0011 NOP.
  - 0100-1111 ALU: RX <- RX fn RY, with ALUFN=OP.
- State transitions (on the rising CLKb edge with STEP=1):
  - FETCH: Ext=1, IRin=1 -> EX1. IR captures BUS at this edge; EX1 decodes the new INSTR.
  - EX1, LD: Ext=1, ENW=1, WRA=RX, DONE=1 -> FETCH.
  - EX1, MV: ENR=1, RDA=RY, ENW=1, WRA=RX, DONE=1 -> FETCH. RX=RY is legal and a no-op write.
  - EX1, NOP: DONE=1 -> FETCH.
  - EX1, HALT: no strobes -> HALT.
  - EX1, ALU: ENR=1, RDA=RX, Ain=1 -> EX2.
  - EX2: ENR=1, RDA=RY, Gin=1, ALUFN=OP -> EX3.
  - EX3: Gout=1, ENW=1, WRA=RX, ALUFN=OP, DONE=1 -> FETCH.
  - HALT: all strobes 0, HALTED=1; leaves only on reset.
- Latency per instruction, in STEP cycles: LD/MV/NOP = 2, ALU = 4.
- Outputs are combinational from the state register, INSTR and STEP.
  - With STEP=0: the state holds and every strobe and enable is 0 (IRin, Ext, ENW, ENR, Ain, Gin, Gout, DONE). TSTEP and HALTED still reflect the state.
  - When the matching enable is low, WRA, RDA and ALUFN output 0.
- Bus exclusivity invariant: in every cycle, Ext + ENR + Gout <= 1.
- Reset (RSTb=0, asynchronous, any time including mid-instruction):
  - State goes to FETCH immediately.
  - All outputs are 0, TSTEP=0, HALTED=0.
  - A partially executed ALU op is abandoned; A/G contents are don't-care.
- Reset release: the first rising edge with STEP=1 performs the FETCH.
- An INSTR change while in EX2/EX3 is a datapath error. Decode uses live INSTR; the IR only loads in FETCH, so INSTR is stable by construction.

Optional Feature:
INSTR_CNT_EN
- Defined: adds output RETIRED[7:0].
  - Increments on each rising edge where DONE=1 and STEP=1; wraps 255 -> 0.
  - Reset to 0 by RSTb; HALT does not count.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, STEP=1, INSTR=0000_10_00_00 (LD R2) -> FETCH: Ext=1, IRin=1, TSTEP=0. Next cycle: Ext=1, ENW=1, WRA=2, DONE=1. Then back to TSTEP=0.
- INSTR=0001_01_11_00 (MV R1<-R3) -> EX1: ENR=1, RDA=3, ENW=1, WRA=1, DONE=1, Ext=0, Gout=0.
- INSTR=0101_00_01_00 (ALU fn 5, R0<-R0,R1):
  - EX1: ENR=1, RDA=0, Ain=1.
  - EX2: RDA=1, Gin=1, ALUFN=5.
  - EX3: Gout=1, ENW=1, WRA=0, DONE=1.
  - Total 4 cycles.
- STEP=0 held 3 cycles while in EX2 -> TSTEP stays 2, all strobes 0. STEP=1 -> proceeds to EX3 with Gout=1.
- INSTR=0010_xx_xx_xx (HALT) -> TSTEP=7, HALTED=1, no strobes for 10 cycles. RSTb pulse low -> TSTEP=0, HALTED=0.
- RSTb asserted mid-EX2, asynchronously between edges -> outputs go to 0 and TSTEP=0 without waiting for a clock. Bus-exclusivity assertion holds over a random 1000-instruction run. With INSTR_CNT_EN defined, RETIRED equals the count of non-HALT instructions mod 256.
